// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: bus-master sequencer for one timer slot.
// On an accepted start it programs auto-reload (addr 1), event-generation
// (addr 3) and control (addr 2), polls the counter (addr 0) every POLL_GAP
// cycles, reports terminal-count events, and disables the timer on a one-shot
// completion or a stop request.
// Ports:
//   clk, arst_n                       clock, async active-low reset
//   start, stop, cfg_arr/down/reload  command port
//   busy, done_irq, evt_cnt, err      status (all registered)
//   t_cs/t_read/t_write/t_addr/t_wdata  timer slot master side (registered)
//   t_rdata, t_rd_done, t_wr_done, t_slave_err, t_decode_err  timer responses
module timer_seq_ctrl #(
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned EVT_W       = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cfg_arr,
  input  logic             cfg_down,
  input  logic             cfg_reload,
  output logic             busy,
  output logic             done_irq,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             err,
  output logic             t_cs,
  output logic             t_read,
  output logic             t_write,
  output logic [3:0]       t_addr,
  output logic [31:0]      t_wdata,
  input  logic [31:0]      t_rdata,
  input  logic             t_rd_done,
  input  logic             t_wr_done,
  input  logic             t_slave_err,
  input  logic             t_decode_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ARR, S_ACK_ARR, S_WR_EG, S_ACK_EG, S_WR_CTL, S_ACK_CTL,
    S_GAP, S_RD_CNT, S_WR_OFF, S_ACK_OFF
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        cfg_arr_q, cfg_arr_d;
  logic               cfg_down_q, cfg_down_d;
  logic               cfg_reload_q, cfg_reload_d;
  logic               stop_q, stop_d;
  logic               hit_prev_q, hit_prev_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [EVT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic               err_q, err_d;
  logic               done_irq_q, done_irq_d;
  logic               busy_q, busy_d;
  logic               t_cs_q, t_cs_d;
  logic               t_read_q, t_read_d;
  logic               t_write_q, t_write_d;
  logic [3:0]         t_addr_q, t_addr_d;
  logic [31:0]        t_wdata_q, t_wdata_d;

  state_e ack_next;
  logic   bus_err;
  logic   hit;
  logic   hit_rise;

  // Successor of each write-acknowledge state
  always_comb begin
    ack_next = S_IDLE;
    unique case (state_q)
      S_ACK_ARR: ack_next = S_WR_EG;
      S_ACK_EG:  ack_next = S_WR_CTL;
      S_ACK_CTL: ack_next = S_GAP;
      default:   ack_next = S_IDLE;
    endcase
  end

  assign bus_err  = t_slave_err | t_decode_err;
  assign hit      = cfg_down_q ? (t_rdata == 32'd0) : (t_rdata >= cfg_arr_q);
  assign hit_rise = hit & ~hit_prev_q;

  // Next-state and status logic
  always_comb begin
    state_d      = state_q;
    cfg_arr_d    = cfg_arr_q;
    cfg_down_d   = cfg_down_q;
    cfg_reload_d = cfg_reload_q;
    stop_d       = stop_q;
    hit_prev_d   = hit_prev_q;
    gap_d        = gap_q;
    tmo_d        = tmo_q;
    evt_cnt_d    = evt_cnt_q;
    err_d        = err_q;
    done_irq_d   = 1'b0;

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_arr_d    = cfg_arr;
          cfg_down_d   = cfg_down;
          cfg_reload_d = cfg_reload;
          evt_cnt_d    = '0;
          err_d        = 1'b0;
          stop_d       = 1'b0;
          hit_prev_d   = 1'b0;
          gap_d        = '0;
          tmo_d        = '0;
          state_d      = S_WR_ARR;
        end
      end
      S_WR_ARR, S_WR_EG, S_WR_CTL, S_WR_OFF: begin
        tmo_d = '0;
        if (bus_err) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Each write state is directly followed by its ack state
          state_d = state_e'(4'(state_q) + 4'd1);
        end
      end
      S_ACK_ARR, S_ACK_EG, S_ACK_CTL, S_ACK_OFF: begin
        if (t_wr_done) begin
          tmo_d   = '0;
          state_d = ack_next;
        end else if (tmo_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == CNT_W'(POLL_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_RD_CNT;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      S_RD_CNT: begin
        if (bus_err || !t_rd_done) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          hit_prev_d = hit;
          if (hit_rise) begin
            done_irq_d = 1'b1;
            if (evt_cnt_q != {EVT_W{1'b1}}) evt_cnt_d = evt_cnt_q + EVT_W'(1);
          end
          // A stop arriving in this very cycle also ends the run here
          if (stop_q || stop || (hit_rise && !cfg_reload_q)) state_d = S_WR_OFF;
          else                                               state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive is a function of the upcoming state so it lines up with it
  always_comb begin
    t_cs_d    = 1'b0;
    t_read_d  = 1'b0;
    t_write_d = 1'b0;
    t_addr_d  = 4'd0;
    t_wdata_d = 32'd0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_WR_ARR: begin
        t_cs_d = 1'b1; t_write_d = 1'b1; t_addr_d = 4'd1;
        t_wdata_d = cfg_arr_d;
      end
      S_WR_EG: begin
        t_cs_d = 1'b1; t_write_d = 1'b1; t_addr_d = 4'd3;
        t_wdata_d = {31'd0, cfg_reload_d};
      end
      S_WR_CTL: begin
        t_cs_d = 1'b1; t_write_d = 1'b1; t_addr_d = 4'd2;
        t_wdata_d = {30'd0, cfg_down_d, 1'b1};
      end
      S_RD_CNT: begin
        t_cs_d = 1'b1; t_read_d = 1'b1; t_addr_d = 4'd0;
      end
      S_WR_OFF: begin
        t_cs_d = 1'b1; t_write_d = 1'b1; t_addr_d = 4'd2;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      cfg_arr_q    <= '0;
      cfg_down_q   <= 1'b0;
      cfg_reload_q <= 1'b0;
      stop_q       <= 1'b0;
      hit_prev_q   <= 1'b0;
      gap_q        <= '0;
      tmo_q        <= '0;
      evt_cnt_q    <= '0;
      err_q        <= 1'b0;
      done_irq_q   <= 1'b0;
      busy_q       <= 1'b0;
      t_cs_q       <= 1'b0;
      t_read_q     <= 1'b0;
      t_write_q    <= 1'b0;
      t_addr_q     <= '0;
      t_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cfg_arr_q    <= cfg_arr_d;
      cfg_down_q   <= cfg_down_d;
      cfg_reload_q <= cfg_reload_d;
      stop_q       <= stop_d;
      hit_prev_q   <= hit_prev_d;
      gap_q        <= gap_d;
      tmo_q        <= tmo_d;
      evt_cnt_q    <= evt_cnt_d;
      err_q        <= err_d;
      done_irq_q   <= done_irq_d;
      busy_q       <= busy_d;
      t_cs_q       <= t_cs_d;
      t_read_q     <= t_read_d;
      t_write_q    <= t_write_d;
      t_addr_q     <= t_addr_d;
      t_wdata_q    <= t_wdata_d;
    end
  end

  assign busy     = busy_q;
  assign done_irq = done_irq_q;
  assign evt_cnt  = evt_cnt_q;
  assign err      = err_q;
  assign t_cs     = t_cs_q;
  assign t_read   = t_read_q;
  assign t_write  = t_write_q;
  assign t_addr   = t_addr_q;
  assign t_wdata  = t_wdata_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl with a small behavioural timer slave.
// The timer counter advances once every 8 clocks so each counter value is
// visible for longer than one poll period.
module tb_timer_seq_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, stop;
  logic [31:0] cfg_arr;
  logic        cfg_down, cfg_reload;
  logic        busy, done_irq, err;
  logic [15:0] evt_cnt;
  logic        t_cs, t_read, t_write;
  logic [3:0]  t_addr;
  logic [31:0] t_wdata, t_rdata;
  logic        t_rd_done, t_wr_done, t_slave_err, t_decode_err;

  // Fault-injection knobs
  logic suppress_wr, inj_slave, rd_fail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_seq_ctrl #(.POLL_GAP(4), .ACK_TIMEOUT(8), .EVT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .stop(stop),
    .cfg_arr(cfg_arr), .cfg_down(cfg_down), .cfg_reload(cfg_reload),
    .busy(busy), .done_irq(done_irq), .evt_cnt(evt_cnt), .err(err),
    .t_cs(t_cs), .t_read(t_read), .t_write(t_write), .t_addr(t_addr),
    .t_wdata(t_wdata), .t_rdata(t_rdata), .t_rd_done(t_rd_done),
    .t_wr_done(t_wr_done), .t_slave_err(t_slave_err), .t_decode_err(t_decode_err)
  );

  // Timer slave model
  logic [31:0] m_arr, m_eg, m_cnt;
  logic        m_en, m_down, m_wr_pend;
  logic [2:0]  m_pre;

  assign t_rdata      = m_cnt;
  assign t_rd_done    = t_cs & t_read & ~rd_fail;
  assign t_wr_done    = m_wr_pend;
  assign t_slave_err  = inj_slave & t_cs & t_write & (t_addr == 4'd3);
  assign t_decode_err = 1'b0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_arr <= '0; m_eg <= '0; m_cnt <= '0; m_en <= 1'b0; m_down <= 1'b0;
      m_wr_pend <= 1'b0; m_pre <= '0;
    end else begin
      m_wr_pend <= t_cs & t_write & ~suppress_wr & ~t_slave_err;
      if (t_cs && t_write && !t_slave_err) begin
        case (t_addr)
          4'd1: m_arr <= t_wdata;
          4'd3: m_eg  <= t_wdata;
          4'd2: begin
            m_en   <= t_wdata[0];
            m_down <= t_wdata[1];
            m_cnt  <= t_wdata[1] ? m_arr : 32'd0;
            m_pre  <= '0;
          end
          default: ;
        endcase
      end else if (m_en) begin
        m_pre <= m_pre + 3'd1;
        if (m_pre == 3'd7) begin
          if (!m_down) begin
            if (m_cnt >= m_arr) m_cnt <= m_eg[0] ? 32'd0 : m_cnt;
            else                m_cnt <= m_cnt + 32'd1;
          end else begin
            if (m_cnt == 32'd0) m_cnt <= m_eg[0] ? m_arr : 32'd0;
            else                m_cnt <= m_cnt - 32'd1;
          end
        end
      end
    end
  end

  // Bus access log and pulse monitor
  typedef struct packed {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t log_q[$];
  int   done_pulses = 0;
  int   done_wide   = 0;
  int   bus_viol    = 0;
  logic done_prev   = 1'b0;

  always @(negedge clk) begin
    if (t_cs) begin
      log_q.push_back({t_read, t_addr, t_read ? t_rdata : t_wdata});
      if (t_read == t_write) bus_viol++;
    end else if (t_read || t_write || t_addr != 4'd0 || t_wdata != 32'd0) begin
      bus_viol++;
    end
    if (done_irq) begin
      done_pulses++;
      if (done_prev) done_wide++;
    end
    done_prev = done_irq;
  end

  function automatic acc_t acc(input int i);
    if (i >= 0 && i < log_q.size()) return log_q[i];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] arr, input logic down, input logic rel);
    cfg_arr = arr; cfg_down = down; cfg_reload = rel; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Checks a completed one-shot run logged from index b
  task automatic chk_oneshot(input string tag, input int b, input logic [31:0] arr,
                             input logic down, input logic [31:0] last_rd, input int p0);
    int last;
    int bad;
    last = log_q.size() - 1;
    bad  = 0;
    chk({tag, "_w_arr"}, 32'(acc(b)),     32'({1'b0, 4'd1, arr}));
    chk({tag, "_w_eg"},  32'(acc(b + 1)), 32'({1'b0, 4'd3, 32'd0}));
    chk({tag, "_w_ctl"}, 32'(acc(b + 2)), 32'({1'b0, 4'd2, 30'd0, down, 1'b1}));
    chk({tag, "_w_off"}, 32'(acc(last) >> 32), 32'({1'b0, 4'd2}));
    chk({tag, "_off_data"}, acc(last).data, 32'd0);
    for (int i = b + 3; i < last; i++)
      if (!acc(i).rd || acc(i).addr != 4'd0) bad++;
    chk({tag, "_reads_only"}, 32'(bad), 32'd0);
    chk({tag, "_nreads"}, 32'(last - b - 3 >= 2), 32'd1);
    chk({tag, "_last_rd"}, acc(last - 1).data, last_rd);
    chk({tag, "_pulses"}, 32'(done_pulses - p0), 32'd1);
    chk({tag, "_evt"}, 32'(evt_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int b, p0, n;
    arst_n = 1'b0; start = 1'b1; stop = 1'b0;
    cfg_arr = 32'h55; cfg_down = 1'b1; cfg_reload = 1'b1;
    suppress_wr = 1'b0; inj_slave = 1'b0; rd_fail = 1'b0;

    // Reset with start held high
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_irq), 32'd0);
    chk("rst_evt", 32'(evt_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bus", 32'({t_cs, t_read, t_write, t_addr}), 32'd0);
    chk("rst_wdata", t_wdata, 32'd0);
    start = 1'b0;
    arst_n = 1'b1;
    b = log_q.size();
    repeat (5) step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_nobus", 32'(log_q.size() - b), 32'd0);

    // One-shot, up, arr=10
    b = log_q.size(); p0 = done_pulses;
    do_start(32'd10, 1'b0, 1'b0);
    chk("os_busy", 32'(busy), 32'd1);
    wait_idle(1500, "os_up_idle");
    chk_oneshot("os_up", b, 32'd10, 1'b0, 32'd10, p0);

    // One-shot, down, arr=5
    b = log_q.size(); p0 = done_pulses;
    do_start(32'd5, 1'b1, 1'b0);
    wait_idle(1500, "os_dn_idle");
    chk_oneshot("os_dn", b, 32'd5, 1'b1, 32'd0, p0);

    // Continuous, up, arr=20: three events then stop
    b = log_q.size(); p0 = done_pulses;
    do_start(32'd20, 1'b0, 1'b1);
    chk("cont_w_eg", 32'(acc(b + 1).data), 32'd0);
    n = 0;
    while (evt_cnt != 16'd3 && n < 3000) begin step(); n++; end
    chk("cont_evt3", 32'(evt_cnt), 32'd3);
    chk("cont_pulses", 32'(done_pulses - p0), 32'd3);
    chk("cont_w_eg_data", acc(b + 1).data, 32'd1);
    n = 0;
    while (t_cs && n < 10) begin step(); n++; end
    b = log_q.size();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(100, "cont_stop_idle");
    chk("cont_stop_nacc", 32'(log_q.size() - b), 32'd2);
    chk("cont_stop_rd", 32'(acc(b) >> 32), 32'({1'b1, 4'd0}));
    chk("cont_stop_off", 32'(acc(b + 1)), 32'({1'b0, 4'd2, 32'd0}));
    chk("cont_evt_hold", 32'(evt_cnt), 32'd3);
    chk("cont_pulses_hold", 32'(done_pulses - p0), 32'd3);

    // Slave error on the event-generation write
    inj_slave = 1'b1;
    b = log_q.size();
    do_start(32'd10, 1'b0, 1'b0);
    n = 0;
    while (!(t_cs && t_write && t_addr == 4'd3) && n < 50) begin step(); n++; end
    chk("serr_seen_eg", 32'(t_cs && t_addr == 4'd3), 32'd1);
    step();
    chk("serr_busy", 32'(busy), 32'd0);
    chk("serr_err", 32'(err), 32'd1);
    inj_slave = 1'b0;
    repeat (20) step();
    chk("serr_nacc", 32'(log_q.size() - b), 32'd2);
    chk("serr_err_sticky", 32'(err), 32'd1);
    do_start(32'd10, 1'b0, 1'b0);
    chk("serr_clr", 32'(err), 32'd0);
    wait_idle(1500, "serr_rerun_idle");
    chk("serr_rerun_evt", 32'(evt_cnt), 32'd1);

    // Write-ack timeout on the auto-reload write
    suppress_wr = 1'b1;
    do_start(32'd10, 1'b0, 1'b0);
    chk("tmo_issue", 32'({t_cs, t_write, t_addr}), 32'({1'b1, 1'b1, 4'd1}));
    n = 0;
    step();
    while (busy && n < 50) begin n++; step(); end
    chk("tmo_wait_cycles", 32'(n), 32'd8);
    chk("tmo_err", 32'(err), 32'd1);
    suppress_wr = 1'b0;

    // Read without rd_done
    rd_fail = 1'b1;
    b = log_q.size();
    do_start(32'd10, 1'b0, 1'b0);
    wait_idle(200, "rdf_idle");
    chk("rdf_err", 32'(err), 32'd1);
    chk("rdf_last_rd", 32'(acc(log_q.size() - 1) >> 32), 32'({1'b1, 4'd0}));
    chk("rdf_nacc", 32'(log_q.size() - b), 32'd4);
    rd_fail = 1'b0;

    // start while busy with a new cfg_arr is ignored
    b = log_q.size(); p0 = done_pulses;
    do_start(32'd10, 1'b0, 1'b0);
    repeat (2) step();
    cfg_arr = 32'd50; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(1500, "bst_idle");
    chk_oneshot("bst", b, 32'd10, 1'b0, 32'd10, p0);

    // Reset mid-sequence
    b = log_q.size();
    do_start(32'd10, 1'b0, 1'b0);
    repeat (3) step();
    arst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_bus", 32'({t_cs, t_read, t_write, t_addr}), 32'd0);
    step();
    arst_n = 1'b1;
    n = log_q.size();
    repeat (10) step();
    chk("mrst_idle", 32'(busy), 32'd0);
    chk("mrst_no_off", 32'(log_q.size() - n), 32'd0);

    // Global bus and pulse-shape invariants
    chk("bus_rules", 32'(bus_viol), 32'd0);
    chk("done_single", 32'(done_wide), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Bus-master sequencer that configures and runs one `timer` slot without CPU involvement. On a `start` command it programs the timer's auto-reload, event-generation and control registers in that order. It then polls the counter register and reports terminal-count events. It finally disables the timer on completion or on a `stop` request. It sits between a simple command port (CPU/DMA glue) and the timer's slot interface; it is the only master on that slot.

Parameters:
POLL_GAP, 4, idle cycles between consecutive counter reads (1..255)
ACK_TIMEOUT, 8, cycles to wait for wr_done after a write issue before flagging error (2..255)
EVT_W, 16, width of event counter

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
start  input  1  command: begin sequence (accepted only in IDLE)
stop  input  1  command: abort/finish running sequence
cfg_arr  input  32  auto-reload value, captured on accepted start
cfg_down  input  1  1=count down, 0=count up; captured on start
cfg_reload  input  1  1=auto-restart (continuous), 0=one-shot; captured on start
busy  output  1  high in every state except IDLE
done_irq  output  1  one-cycle pulse per detected terminal-count event
evt_cnt  output  EVT_W  terminal-count events since last accepted start (saturating)
err  output  1  sticky error, cleared on next accepted start
t_cs  output  1  timer chip_select
t_read  output  1  timer read
t_write  output  1  timer write
t_addr  output  4  timer register address
t_wdata  output  32  timer write data
t_rdata  input  32  timer read data (valid same cycle as t_read)
t_rd_done  input  1  timer read done (combinational, same cycle)
t_wr_done  input  1  timer write done (registered, one cycle after issue)
t_slave_err  input  1  timer illegal-access error (same cycle as issue)
t_decode_err  input  1  timer bad-address error (same cycle as issue)

Behaviour:
- Reset is asynchronous and active-low on arst_n; clock is clk. Under reset, every output is 0, the FSM is in IDLE, and all captured config, the stop latch, the edge register and the poll/timeout counters are 0.
- Bus rules:
  - Every access is exactly one cycle with t_cs=1 and exactly one of t_read/t_write set.
  - Outside an issue cycle, t_cs/t_read/t_write=0, t_addr=0 and t_wdata=0.
  - A write issue is followed by a wait state (bus idle) until t_wr_done=1. A timeout counter counts wait cycles; reaching ACK_TIMEOUT without t_wr_done sets err and returns to IDLE.
  - A read completes in its issue cycle. t_rd_done must be 1; if it is 0, set err and return to IDLE.
  - If t_slave_err or t_decode_err is 1 in any issue cycle, set err and go to IDLE immediately. The timer is left as-is.
- FSM states and transitions:
  - IDLE: start=1 captures cfg_*, clears evt_cnt, err, the stop latch and the edge register, then goes to WR_ARR. start while busy is ignored.
  - WR_ARR: issue write addr 1 with data cfg_arr, then go to ACK_ARR.
  - ACK_ARR: on t_wr_done go to WR_EG.
  - WR_EG: issue write addr 3 with data {31'b0, cfg_reload}, then go to ACK_EG.
  - ACK_EG: on t_wr_done go to WR_CTL.
  - WR_CTL: issue write addr 2 with data {30'b0, cfg_down, 1'b1}, then go to ACK_CTL.
  - ACK_CTL: on t_wr_done go to GAP.
  - GAP: count POLL_GAP cycles, then go to RD_CNT.
  - RD_CNT: issue read addr 0 and evaluate `hit` as defined below. Then:
    - go to WR_OFF if stop is latched, or if hit_rise and cfg_reload=0;
    - otherwise go back to GAP.
  - WR_OFF: issue write addr 2 with data 0, then go to ACK_OFF.
  - ACK_OFF: on t_wr_done go to IDLE.
- Terminal-count detection in RD_CNT:
  - Up mode: hit = (t_rdata >= cfg_arr), unsigned compare.
  - Down mode: hit = (t_rdata == 0).
  - hit_rise = hit & !hit_prev; hit_prev updates on every RD_CNT.
  - hit_rise pulses done_irq in the cycle after RD_CNT and increments evt_cnt, saturating at all-ones.
- Stop:
  - stop=1 in any non-IDLE state sets the stop latch.
  - A write in flight completes its ACK state first.
  - In states before ACK_CTL completes, the configuration sequence continues to GAP. It then exits on the first RD_CNT (stop is checked after that read), so WR_OFF is always reached through RD_CNT.
  - stop in IDLE is ignored.
- Simultaneous start and stop in IDLE: start is accepted and stop is ignored in that cycle.
- Reload mode requires timer period > POLL_GAP+2 cycles. Shorter periods may miss events; this is documented, not an error.
- arst_n asserted mid-sequence returns to IDLE immediately, with outputs as at reset. No disable write is issued.

Test Plan:
- Reset: hold arst_n=0 with start=1 → all outputs 0; after release, busy=0 and no bus activity.
- One-shot up, cfg_arr=10, POLL_GAP=4, timer attached → writes (1,10), (3,0), (2,1) in order, each followed by wr_done one cycle later. Reads of addr 0 continue until rd_data>=10, then done_irq is high exactly one cycle and evt_cnt=1. A write (2,0) follows, then busy=0.
- Continuous up, cfg_arr=20, cfg_reload=1 → after 3 timer periods, evt_cnt=3 with 3 single-cycle done_irq pulses. Pulse stop → write (2,0) after the next read, then busy=0, evt_cnt stays 3.
- Error injection: force t_slave_err=1 during the WR_EG issue → err=1, busy=0 next cycle, no further bus access. A following start clears err.
- Timeout: suppress t_wr_done after WR_ARR, ACK_TIMEOUT=8 → err=1 and IDLE after 8 wait cycles.
- start pulsed while busy and cfg_arr changed → ignored; the running sequence uses the original cfg_arr.
